hazard_fwd_unit: RTL and testbench
==================================

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, meaning register-index width (x0..x31).
REQ-002 SHALL have parameter SEL_W, default 2, meaning operand-select width, matching the 4:1 operand mux select.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port i_id_valid, input, 1, meaning a valid instruction is in decode.
REQ-006 SHALL have ports i_id_rs1 and i_id_rs2, input, REG_ADDR_W each, meaning the decode source registers.
REQ-007 SHALL have ports i_id_rs1_used and i_id_rs2_used, input, 1 each, meaning the instruction reads that source.
REQ-008 SHALL have port i_id_rd, input, REG_ADDR_W, meaning the decode destination register.
REQ-009 SHALL have ports i_id_reg_write and i_id_is_load, input, 1 each, meaning the decode instruction writes rd / is a load.
REQ-010 SHALL have port i_flush, input, 1, meaning a taken branch or jump that kills decode and EX.
REQ-011 SHALL have ports o_fwd_sel_a and o_fwd_sel_b, output, SEL_W each, meaning the operand select: 00 regfile, 01 EX result, 10 MEM result, 11 WB result.
REQ-012 SHALL have port o_stall, output, 1, meaning hold PC and IF/ID and inject a bubble into EX.

Function
REQ-013 SHALL track three entries, EX, MEM and WB, each holding {valid, rd, reg_write, is_load}; all entries shift one stage per cycle.
REQ-014 SHALL load the EX entry from the decode inputs when i_id_valid=1 and o_stall=0; otherwise it loads a bubble (valid=0).
REQ-015 SHALL consider a source matched by a stage only if the source is used, the stage is valid with reg_write=1, rd equals the source, and rd is not 0.
REQ-016 SHALL resolve select priority as EX over MEM over WB, so the youngest producer wins; with no match the select is 00.
REQ-017 SHALL compute o_fwd_sel_a, o_fwd_sel_b and o_stall combinationally from the current entries and decode inputs, with zero-cycle latency.
REQ-018 SHALL assert o_stall for one cycle on a load-use hazard (EX entry is_load=1 and matches a used source); the next cycle the load sits in MEM and the select is 10.
REQ-019 SHALL implement an FSM with states IDLE and STALL. IDLE->STALL on a hazard. STALL->IDLE once no hazard remains. STALL must never persist while the EX entry holds a bubble.
REQ-020 SHALL, on i_flush=1, load a bubble into EX regardless of stall and return the FSM to IDLE; MEM and WB still shift normally.
REQ-021 SHALL give flush priority over stall when both occur in the same cycle; o_stall is 0 during flush.
REQ-022 SHALL force o_stall=0 and both selects to 00 when i_id_valid=0.

Reset
REQ-023 SHALL, while i_rst_n=0, clear all entries to valid=0, put the FSM in IDLE, drive o_stall=0 and drive both selects to 00.
REQ-024 SHALL cleanly discard an in-flight stall when reset is asserted mid-stall; the first cycle after release behaves as an empty pipeline.

Configuration
REQ-025 SHALL, when macro HAZARD_FWD_EN is defined, forward per REQ-016 and REQ-018.
REQ-026 SHALL, when HAZARD_FWD_EN is undefined, hold both selects at 00 and stall on any match in EX, MEM or WB; the stall may then last up to 3 consecutive cycles.

Structure
REQ-027 SHALL place the select encodings (SEL_RF, SEL_EX, SEL_MEM, SEL_WB), the FSM state encodings and the stage-entry width in the shared package, alongside `DATA_WIDTH.
REQ-028 SHALL use one sub-module, hazard_stage_reg: a single entry register with async active-low clear and bubble-load control, instantiated three times.

Verification
REQ-029 SHALL cover: add x5 then sub x6,x5,x1 back-to-back -> sel_a=01, stall=0.
REQ-030 SHALL cover: lw x7 then add x8,x7,x7 -> stall=1 for one cycle, then sel_a=sel_b=10.
REQ-031 SHALL cover: write to x0 followed by a reader of x0 -> sel=00, stall=0.
REQ-032 SHALL cover: x9 written by the instructions in both MEM and WB, decode reads x9 -> sel=10 (youngest wins).
REQ-033 SHALL cover: load-use hazard with i_flush=1 in the same cycle -> stall=0, next EX entry is a bubble.
REQ-034 SHALL cover: with HAZARD_FWD_EN undefined, a back-to-back add dependency -> stall=1 for 3 cycles, selects 00, then release.

Source files
------------

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared encodings for the hazard/forwarding unit: operand-mux selects,
// FSM states and the width of one pipeline-stage tracking entry.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package hazard_fwd_unit_pkg;

  localparam int DATA_W = `DATA_WIDTH;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } hz_state_e;

  // Entry layout, MSB to LSB: {valid, rd, reg_write, is_load}.
  localparam int ENTRY_FLAG_W = 3;
  localparam int ENTRY_W      = 5 + ENTRY_FLAG_W;

  function automatic int entry_width(input int reg_addr_w);
    return reg_addr_w + ENTRY_FLAG_W;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline-stage tracking entry. Loading a bubble clears the whole entry,
// which also clears its valid bit.
module hazard_stage_reg #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_bubble,
  input  logic [W-1:0] i_entry,
  output logic [W-1:0] o_entry
);

  logic [W-1:0] entry_q;
  logic [W-1:0] entry_d;

  assign entry_d = i_bubble ? '0 : i_entry;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign o_entry = entry_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for a 5-stage pipeline.
// Define HAZARD_FWD_EN to forward from EX/MEM/WB; otherwise every hazard stalls.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_reg_write,
  input  logic                  i_id_is_load,
  input  logic                  i_flush,
  output logic [SEL_W-1:0]      o_fwd_sel_a,
  output logic [SEL_W-1:0]      o_fwd_sel_b,
  output logic                  o_stall
);

  localparam int EW = entry_width(REG_ADDR_W);

  logic [EW-1:0]    id_entry;
  logic [EW-1:0]    ex_q;
  logic [EW-1:0]    mem_q;
  logic [EW-1:0]    wb_q;
  logic             ex_bubble;
  logic             hazard;
  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  hz_state_e        state_q;
  hz_state_e        state_d;
  logic             unused_bits;

  assign id_entry  = {i_id_valid, i_id_rd, i_id_reg_write, i_id_is_load};
  assign ex_bubble = !i_id_valid || o_stall || i_flush;

  hazard_stage_reg #(.W(EW)) u_ex (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_bubble(ex_bubble),
    .i_entry(id_entry), .o_entry(ex_q)
  );

  hazard_stage_reg #(.W(EW)) u_mem (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_bubble(1'b0),
    .i_entry(ex_q), .o_entry(mem_q)
  );

  hazard_stage_reg #(.W(EW)) u_wb (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_bubble(1'b0),
    .i_entry(mem_q), .o_entry(wb_q)
  );

  // A stage produces a source only if it is a live writer of that non-x0 register.
  function automatic logic hit(input logic [EW-1:0] e,
                               input logic [REG_ADDR_W-1:0] src,
                               input logic used);
    return used && e[EW-1] && e[1] && (e[EW-2:2] == src) && (e[EW-2:2] != '0);
  endfunction

`ifdef HAZARD_FWD_EN
  function automatic logic [SEL_W-1:0] pick(input logic [EW-1:0] ex,
                                            input logic [EW-1:0] mem,
                                            input logic [EW-1:0] wb,
                                            input logic [REG_ADDR_W-1:0] src,
                                            input logic used);
    if (hit(ex, src, used))       return SEL_W'(SEL_EX);
    else if (hit(mem, src, used)) return SEL_W'(SEL_MEM);
    else if (hit(wb, src, used))  return SEL_W'(SEL_WB);
    else                          return SEL_W'(SEL_RF);
  endfunction
`endif

  always_comb begin
    hazard = 1'b0;
    sel_a  = SEL_W'(SEL_RF);
    sel_b  = SEL_W'(SEL_RF);
`ifdef HAZARD_FWD_EN
    sel_a  = pick(ex_q, mem_q, wb_q, i_id_rs1, i_id_rs1_used);
    sel_b  = pick(ex_q, mem_q, wb_q, i_id_rs2, i_id_rs2_used);
    hazard = ex_q[0] && (hit(ex_q, i_id_rs1, i_id_rs1_used) ||
                         hit(ex_q, i_id_rs2, i_id_rs2_used));
`else
    hazard = hit(ex_q,  i_id_rs1, i_id_rs1_used) || hit(ex_q,  i_id_rs2, i_id_rs2_used) ||
             hit(mem_q, i_id_rs1, i_id_rs1_used) || hit(mem_q, i_id_rs2, i_id_rs2_used) ||
             hit(wb_q,  i_id_rs1, i_id_rs1_used) || hit(wb_q,  i_id_rs2, i_id_rs2_used);
`endif
    if (!i_id_valid) begin
      hazard = 1'b0;
      sel_a  = SEL_W'(SEL_RF);
      sel_b  = SEL_W'(SEL_RF);
    end
  end

  assign o_stall     = hazard && !i_flush;
  assign o_fwd_sel_a = sel_a;
  assign o_fwd_sel_b = sel_b;

  // A stall injects a bubble into EX, so the hazard clears by itself and STALL drops back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (o_stall) state_d = ST_STALL;
      ST_STALL: if (i_flush || !o_stall) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign unused_bits = ^{ex_q[0], mem_q[0], wb_q[0]};

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed pipeline scenarios plus
// randomized instruction streams checked against an instruction-history model.
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic       id_rs1_used = 1'b0;
  logic       id_rs2_used = 1'b0;
  logic [4:0] id_rd = '0;
  logic       id_reg_write = 1'b0;
  logic       id_is_load = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] fwd_sel_a;
  logic [1:0] fwd_sel_b;
  logic       stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_rs1_used(id_rs1_used), .i_id_rs2_used(id_rs2_used),
    .i_id_rd(id_rd), .i_id_reg_write(id_reg_write), .i_id_is_load(id_is_load),
    .i_flush(flush), .o_fwd_sel_a(fwd_sel_a), .o_fwd_sel_b(fwd_sel_b), .o_stall(stall)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       w;
    logic       ld;
    logic       fl;
  } instr_t;

  // History of issued instructions: slot 0 is the youngest (EX), slot 2 the oldest (WB).
  typedef struct {
    logic v;
    int   rd;
    logic w;
    logic ld;
  } slot_t;

  slot_t hist [3];

  function automatic instr_t mk(logic v, int rs1, logic u1, int rs2, logic u2,
                                int rd, logic w, logic ld, logic fl);
    instr_t i;
    i.v = v; i.rs1 = 5'(rs1); i.u1 = u1; i.rs2 = 5'(rs2); i.u2 = u2;
    i.rd = 5'(rd); i.w = w; i.ld = ld; i.fl = fl;
    return i;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 3; k++) hist[k] = '{1'b0, 0, 1'b0, 1'b0};
  endfunction

  function automatic void model_eval(input instr_t ins, output logic [1:0] ea,
                                     output logic [1:0] eb, output logic es);
    logic ha [3];
    logic hb [3];
    logic any;
    for (int k = 0; k < 3; k++) begin
      ha[k] = ins.u1 && hist[k].v && hist[k].w && hist[k].rd == int'(ins.rs1) && ins.rs1 != 0;
      hb[k] = ins.u2 && hist[k].v && hist[k].w && hist[k].rd == int'(ins.rs2) && ins.rs2 != 0;
    end
    ea = 2'd0; eb = 2'd0; es = 1'b0;
    if (ins.v) begin
`ifdef HAZARD_FWD_EN
      for (int k = 2; k >= 0; k--) begin
        if (ha[k]) ea = 2'(k + 1);
        if (hb[k]) eb = 2'(k + 1);
      end
      es = hist[0].ld && (ha[0] || hb[0]);
`else
      any = 1'b0;
      for (int k = 0; k < 3; k++) any = any || ha[k] || hb[k];
      es = any;
`endif
      if (ins.fl) es = 1'b0;
    end
  endfunction

  function automatic void model_update(input instr_t ins, input logic es);
    hist[2] = hist[1];
    hist[1] = hist[0];
    if (ins.v && !es && !ins.fl) hist[0] = '{1'b1, int'(ins.rd), ins.w, ins.ld};
    else                         hist[0] = '{1'b0, 0, 1'b0, 1'b0};
  endfunction

  task automatic drive(input instr_t ins);
    id_valid = ins.v; id_rs1 = ins.rs1; id_rs2 = ins.rs2;
    id_rs1_used = ins.u1; id_rs2_used = ins.u2; id_rd = ins.rd;
    id_reg_write = ins.w; id_is_load = ins.ld; flush = ins.fl;
  endtask

  // Present one instruction in decode, holding it while the unit stalls it.
  task automatic run_instr(input string tag, input instr_t ins, output int stalls,
                           output logic first_stall, output logic [1:0] sa,
                           output logic [1:0] sb);
    logic [1:0] ea, eb;
    logic es;
    logic done;
    drive(ins);
    stalls = 0; done = 1'b0; first_stall = 1'b0; sa = '0; sb = '0;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      model_eval(ins, ea, eb, es);
      checks += 3;
      if (fwd_sel_a !== ea) begin
        errors++; $display("[TB] FAIL %s sel_a: got %0d expected %0d", tag, fwd_sel_a, ea);
      end
      if (fwd_sel_b !== eb) begin
        errors++; $display("[TB] FAIL %s sel_b: got %0d expected %0d", tag, fwd_sel_b, eb);
      end
      if (stall !== es) begin
        errors++; $display("[TB] FAIL %s stall: got %0b expected %0b", tag, stall, es);
      end
      if (c == 0) first_stall = stall;
      sa = fwd_sel_a; sb = fwd_sel_b;
      @(posedge clk);
      model_update(ins, es);
      #1;
      if (!es) done = 1'b1;
      else     stalls++;
    end
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL %s stall_timeout: got %0d stall cycles expected at most 3", tag, stalls);
    end
  endtask

  task automatic drain(input int n);
    int s; logic f; logic [1:0] a, b;
    for (int i = 0; i < n; i++) run_instr("drain", mk(0, 0, 0, 0, 0, 0, 0, 0, 0), s, f, a, b);
  endtask

  task automatic check_scn(input string tag, input int stalls, input int exp_stalls,
                           input logic [1:0] sa, input logic [1:0] exp_sa,
                           input logic [1:0] sb, input logic [1:0] exp_sb);
    checks += 3;
    if (stalls != exp_stalls) begin
      errors++; $display("[TB] FAIL %s stall_cycles: got %0d expected %0d", tag, stalls, exp_stalls);
    end
    if (sa !== exp_sa) begin
      errors++; $display("[TB] FAIL %s final_sel_a: got %0d expected %0d", tag, sa, exp_sa);
    end
    if (sb !== exp_sb) begin
      errors++; $display("[TB] FAIL %s final_sel_b: got %0d expected %0d", tag, sb, exp_sb);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(mk(1, 5, 1, 6, 1, 7, 1, 1, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 3;
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset stall: got %0b expected 0", stall); end
    if (fwd_sel_a !== 2'd0) begin errors++; $display("[TB] FAIL reset sel_a: got %0d expected 0", fwd_sel_a); end
    if (fwd_sel_b !== 2'd0) begin errors++; $display("[TB] FAIL reset sel_b: got %0d expected 0", fwd_sel_b); end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    model_update(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    #1;
  endtask

  task automatic test_ex_forward();
    int s; logic f; logic [1:0] a, b;
    drain(3);
    run_instr("ex_fwd_add", mk(1, 1, 1, 2, 1, 5, 1, 0, 0), s, f, a, b);
    run_instr("ex_fwd_sub", mk(1, 5, 1, 1, 1, 6, 1, 0, 0), s, f, a, b);
`ifdef HAZARD_FWD_EN
    check_scn("ex_fwd", s, 0, a, 2'd1, b, 2'd0);
`else
    check_scn("ex_nofwd", s, 3, a, 2'd0, b, 2'd0);
`endif
  endtask

  task automatic test_load_use();
    int s; logic f; logic [1:0] a, b;
    drain(3);
    run_instr("lu_lw", mk(1, 2, 1, 0, 0, 7, 1, 1, 0), s, f, a, b);
    run_instr("lu_add", mk(1, 7, 1, 7, 1, 8, 1, 0, 0), s, f, a, b);
    checks++;
    if (f !== 1'b1) begin errors++; $display("[TB] FAIL load_use first_stall: got %0b expected 1", f); end
`ifdef HAZARD_FWD_EN
    check_scn("load_use", s, 1, a, 2'd2, b, 2'd2);
`else
    check_scn("load_use_nofwd", s, 3, a, 2'd0, b, 2'd0);
`endif
  endtask

  task automatic test_x0();
    int s; logic f; logic [1:0] a, b;
    drain(3);
    run_instr("x0_wr", mk(1, 1, 1, 0, 0, 0, 1, 0, 0), s, f, a, b);
    run_instr("x0_rd", mk(1, 0, 1, 0, 1, 3, 1, 0, 0), s, f, a, b);
    check_scn("x0", s, 0, a, 2'd0, b, 2'd0);
  endtask

  task automatic test_youngest();
    int s; logic f; logic [1:0] a, b;
    drain(3);
    run_instr("yw_i1", mk(1, 0, 0, 0, 0, 9, 1, 0, 0), s, f, a, b);
    run_instr("yw_i2", mk(1, 0, 0, 0, 0, 9, 1, 0, 0), s, f, a, b);
    run_instr("yw_i3", mk(1, 0, 0, 0, 0, 10, 1, 0, 0), s, f, a, b);
    run_instr("yw_i4", mk(1, 9, 1, 9, 1, 11, 1, 0, 0), s, f, a, b);
`ifdef HAZARD_FWD_EN
    check_scn("youngest", s, 0, a, 2'd2, b, 2'd2);
`else
    check_scn("youngest_nofwd", s, 2, a, 2'd0, b, 2'd0);
`endif
  endtask

  task automatic test_flush_load_use();
    int s; logic f; logic [1:0] a, b;
    drain(3);
    run_instr("fl_lw", mk(1, 2, 1, 0, 0, 7, 1, 1, 0), s, f, a, b);
    run_instr("fl_add", mk(1, 7, 1, 7, 1, 8, 1, 0, 1), s, f, a, b);
    check_scn("flush_cycle", s, 0, 2'd0, 2'd0, 2'd0, 2'd0);
    checks++;
    if (f !== 1'b0) begin errors++; $display("[TB] FAIL flush stall: got %0b expected 0", f); end
    run_instr("fl_next", mk(1, 8, 1, 7, 1, 12, 1, 0, 0), s, f, a, b);
`ifdef HAZARD_FWD_EN
    check_scn("flush_bubble", s, 0, a, 2'd0, b, 2'd2);
`else
    check_scn("flush_bubble_nofwd", s, 2, a, 2'd0, b, 2'd0);
`endif
  endtask

  task automatic test_reset_mid_stall();
    int s; logic f; logic [1:0] a, b;
    drain(3);
    run_instr("rms_lw", mk(1, 2, 1, 0, 0, 7, 1, 1, 0), s, f, a, b);
    drive(mk(1, 7, 1, 7, 1, 8, 1, 0, 0));
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("[TB] FAIL mid_stall pre_reset: got %0b expected 1", stall); end
    #1 rst_n = 1'b0;
    #1;
    checks += 3;
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL mid_stall reset_stall: got %0b expected 0", stall); end
    if (fwd_sel_a !== 2'd0) begin errors++; $display("[TB] FAIL mid_stall reset_sel_a: got %0d expected 0", fwd_sel_a); end
    if (fwd_sel_b !== 2'd0) begin errors++; $display("[TB] FAIL mid_stall reset_sel_b: got %0d expected 0", fwd_sel_b); end
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_instr("rms_after", mk(1, 7, 1, 7, 1, 8, 1, 0, 0), s, f, a, b);
    check_scn("after_reset", s, 0, a, 2'd0, b, 2'd0);
  endtask

  task automatic test_random();
    int s; logic f; logic [1:0] a, b;
    instr_t ins;
    drain(3);
    for (int i = 0; i < 300; i++) begin
      ins = mk(($urandom % 8) != 0, int'($urandom_range(0, 7)), 1'($urandom),
               int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)),
               ($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 10) == 0);
      run_instr("random", ins, s, f, a, b);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_ex_forward();
    test_load_use();
    test_x0();
    test_youngest();
    test_flush_load_use();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
